lab2_proc_muldiv_iter: RTL and testbench

Iterative multiply/divide responder for the lab2 pipelined processor. Sits beside the combinational ALU in the X stage. Accepts MUL/DIV/DIVU/REM/REMU requests from the pipeline over a val/rdy request interface. Returns 32-bit results over a val/rdy response interface after a fixed 32-cycle iteration. It provides the multi-cycle arithmetic the single-cycle ALU cannot.

---
 rtl/lab2_proc_muldiv_iter.sv | 171 +++++++++++++++++
 tb/tb_lab2_proc_muldiv_iter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_muldiv_iter.sv
// Iterative multiply/divide unit for the lab2 processor X stage.
// Handles MUL/DIV/DIVU/REM/REMU with a fixed NBITS-iteration shift-add or restoring-division loop.
module lab2_proc_muldiv_iter #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [2:0]       req_fn,
  input  logic [NBITS-1:0] req_a,
  input  logic [NBITS-1:0] req_b,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] resp_msg
);

  localparam int CW = $clog2(NBITS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  logic [1:0]         state;
  logic [CW-1:0]      counter;
  logic               load;
  logic [2:0]         fn;
  logic [NBITS-1:0]   a_raw;
  logic [NBITS-1:0]   b_raw;
  logic [NBITS-1:0]   opa;
  logic [NBITS-1:0]   opb;
  logic [2*NBITS-1:0] rq;
  logic               neg_q;
  logic               neg_r;
  logic               dbz;
  logic [NBITS-1:0]   result;

  logic [2*NBITS-1:0] rq_nxt;
  logic [NBITS-1:0]   opa_nxt;
  logic [NBITS-1:0]   opb_nxt;
  logic [2*NBITS:0]   shifted;
  logic [NBITS:0]     diff;
  logic [NBITS-1:0]   quot;
  logic [NBITS-1:0]   rem;
  logic [NBITS-1:0]   final_val;

  // |x| of a two's-complement value; the most negative value maps to itself as an unsigned magnitude
  function automatic logic [NBITS-1:0] abs_val(input logic signed [NBITS-1:0] x);
    logic signed [NBITS-1:0] neg;
    neg = -x;
    return (x < 0) ? $unsigned(neg) : $unsigned(x);
  endfunction

  function automatic logic [NBITS-1:0] cond_neg(input logic [NBITS-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  assign req_rdy  = (state == IDLE);
  assign resp_val = (state == DONE);
  assign resp_msg = result;

  // One iteration: shift-add for MUL, shift-compare-subtract for the divide family
  always_comb begin
    rq_nxt  = rq;
    opa_nxt = opa;
    opb_nxt = opb;
    shifted = '0;
    diff    = '0;
    if (fn == FN_MUL) begin
      if (opb[0]) rq_nxt[NBITS-1:0] = rq[NBITS-1:0] + opa;
      opa_nxt = opa << 1;
      opb_nxt = opb >> 1;
    end else begin
      shifted = {rq, 1'b0};
      if (shifted[2*NBITS:NBITS] >= {1'b0, opb}) begin
        diff                     = shifted[2*NBITS:NBITS] - {1'b0, opb};
        shifted[2*NBITS:NBITS]   = diff;
        shifted[0]               = 1'b1;
      end
      rq_nxt = shifted[2*NBITS-1:0];
    end
  end

  assign quot = rq_nxt[NBITS-1:0];
  assign rem  = rq_nxt[2*NBITS-1:NBITS];

  always_comb begin
    final_val = '0;
    case (fn)
      FN_MUL:  final_val = rq_nxt[NBITS-1:0];
      FN_DIV:  final_val = dbz ? '1 : cond_neg(quot, neg_q);
      FN_DIVU: final_val = dbz ? '1 : quot;
      FN_REM:  final_val = dbz ? a_raw : cond_neg(rem, neg_r);
      FN_REMU: final_val = dbz ? a_raw : rem;
      default: final_val = '0;
    endcase
  end

  // Accept latches raw operands and sign flags; the first CALC cycle conditions operands,
  // then NBITS iteration cycles follow, the last of which registers the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
      load    <= 1'b0;
      fn      <= '0;
      a_raw   <= '0;
      b_raw   <= '0;
      opa     <= '0;
      opb     <= '0;
      rq      <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dbz     <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val) begin
            fn      <= req_fn;
            a_raw   <= req_a;
            b_raw   <= req_b;
            neg_q   <= (req_fn == FN_DIV) && (req_a[NBITS-1] != req_b[NBITS-1]);
            neg_r   <= (req_fn == FN_REM) && req_a[NBITS-1];
            dbz     <= (req_b == '0);
            load    <= 1'b1;
            counter <= CW'(NBITS - 1);
            state   <= CALC;
          end
        end
        CALC: begin
          if (load) begin
            load <= 1'b0;
            opa  <= a_raw;
            if (fn == FN_MUL) begin
              rq  <= '0;
              opb <= b_raw;
            end else if (fn == FN_DIV || fn == FN_REM) begin
              rq  <= {{NBITS{1'b0}}, abs_val(a_raw)};
              opb <= abs_val(b_raw);
            end else begin
              rq  <= {{NBITS{1'b0}}, a_raw};
              opb <= b_raw;
            end
          end else begin
            rq  <= rq_nxt;
            opa <= opa_nxt;
            opb <= opb_nxt;
            if (counter == '0) begin
              result <= final_val;
              state  <= DONE;
            end else begin
              counter <= counter - 1'b1;
            end
          end
        end
        DONE: begin
          if (resp_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab2_proc_muldiv_iter.sv
// Self-checking bench for lab2_proc_muldiv_iter: directed vector table, corner sequences,
// and randomized operations compared against an arithmetic reference model.
module tb_lab2_proc_muldiv_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [2:0]  req_fn;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_msg;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lab2_proc_muldiv_iter #(.NBITS(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_fn   (req_fn),
    .req_a    (req_a),
    .req_b    (req_b),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Results straight from the instruction semantics, using native SV arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [63:0]        p;
    sa = a;
    sb = b;
    case (fn)
      3'd0: begin
        p = 64'(a) * 64'(b);
        return p[31:0];
      end
      3'd1: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      3'd2: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd3: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      3'd4: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Caller is #1 after a rising edge; returns #1 after the edge on which resp_val is seen
  task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    int guard = 0;
    while (!req_rdy && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      tests++;
      fails++;
      $display("FAIL req_rdy wait: got 0 after %0d cycles, expected 1", guard);
    end
    req_val = 1'b1;
    req_fn  = fn;
    req_a   = a;
    req_b   = b;
    @(posedge clk); #1;
    req_val = 1'b0;
    lat = 0;
    while (!resp_val && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take(input int delay);
    repeat (delay) begin
      @(posedge clk); #1;
    end
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input int delay, output logic [31:0] res, output int lat);
    issue(fn, a, b, lat);
    res = resp_msg;
    take(delay);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners[0] = 32'h0;
    corners[1] = 32'h1;
    corners[2] = 32'hFFFFFFFF;
    corners[3] = 32'h80000000;
    corners[4] = 32'h7FFFFFFF;
    case ($urandom_range(0, 3))
      0: return corners[$urandom_range(0, 4)];
      1: return 32'($urandom_range(0, 20));
      2: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs [16];
    logic [31:0] res;
    logic [31:0] held;
    logic [31:0] expq [$];
    int          lat;
    int          stale;

    vecs[0]  = '{3'd0, 32'h00000003, 32'h00000004, 32'h0000000C};
    vecs[1]  = '{3'd0, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFB};
    vecs[2]  = '{3'd0, 32'h0FFAA660, 32'h00012304, 32'h2B09B980};
    vecs[3]  = '{3'd1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
    vecs[4]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
    vecs[5]  = '{3'd1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD};
    vecs[6]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001};
    vecs[7]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC};
    vecs[8]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'h00000001};
    vecs[9]  = '{3'd1, 32'h00000005, 32'h00000000, 32'hFFFFFFFF};
    vecs[10] = '{3'd4, 32'h00000005, 32'h00000000, 32'h00000005};
    vecs[11] = '{3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[12] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[13] = '{3'd2, 32'h00000005, 32'h00000000, 32'hFFFFFFFF};
    vecs[14] = '{3'd3, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB};
    vecs[15] = '{3'd5, 32'h00001234, 32'h00000056, 32'h00000000};

    reset    = 1'b0;
    req_val  = 1'b0;
    req_fn   = 3'd0;
    req_a    = 32'h0;
    req_b    = 32'h0;
    resp_rdy = 1'b0;

    #12;
    check("reset req_rdy", 32'(req_rdy), 32'd1);
    check("reset resp_val", 32'(resp_val), 32'd0);
    check("reset resp_msg", resp_msg, 32'h0);
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].fn, vecs[i].a, vecs[i].b, 0, res, lat);
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd33);
    end

    // Backpressure: hold the response and offer a competing request meanwhile
    issue(3'd0, 32'h12345678, 32'h00000009, lat);
    held = resp_msg;
    check("bp result", held, ref_model(3'd0, 32'h12345678, 32'h00000009));
    req_val = 1'b1;
    req_fn  = 3'd0;
    req_a   = 32'h2;
    req_b   = 32'h3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp resp_msg stable", resp_msg, held);
      check("bp req_rdy low", 32'(req_rdy), 32'd0);
      check("bp resp_val high", 32'(resp_val), 32'd1);
    end
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    req_val  = 1'b0;
    check("bp no bypass", 32'(req_rdy), 32'd1);

    // Streaming with random source and sink delays; results must come back in order
    for (int i = 0; i < 3; i++) begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      f = 3'($urandom_range(0, 4));
      a = pick_operand();
      b = pick_operand();
      expq.push_back(ref_model(f, a, b));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      run_op(f, a, b, $urandom_range(0, 4), res, lat);
      check($sformatf("stream%0d", i), res, expq.pop_front());
    end

    // Reset asserted ten cycles into CALC
    req_val = 1'b1;
    req_fn  = 3'd0;
    req_a   = 32'hDEADBEEF;
    req_b   = 32'h12345678;
    @(posedge clk); #1;
    req_val = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midreset req_rdy", 32'(req_rdy), 32'd1);
    check("midreset resp_val", 32'(resp_val), 32'd0);
    check("midreset resp_msg", resp_msg, 32'h0);
    @(posedge clk); #3;
    reset = 1'b1;
    stale = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (resp_val) stale++;
    end
    check("no stale response", 32'(stale), 32'd0);
    run_op(3'd0, 32'd6, 32'd7, 0, res, lat);
    check("post-reset MUL", res, 32'h0000002A);
    check("post-reset latency", 32'(lat), 32'd33);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op(f, a, b, $urandom_range(0, 2), res, lat);
      check($sformatf("rand%0d fn%0d a=%h b=%h", i, f, a, b), res, ref_model(f, a, b));
      check($sformatf("rand%0d latency", i), 32'(lat), 32'd33);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
